// File: rtl/serial_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_rx_pkg
//  Purpose  : Shared state encoding and serial line levels for the framed
//             serial receiver controller.
//  Revision : 1.0  initial release
// ============================================================================
package serial_rx_pkg;

    // Receiver sequencing states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_STOP = 2'd2
    } rx_state_t;

    // Line levels that frame a word: idle/stop high, start low
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage : serial_rx_pkg
`default_nettype wire

// File: rtl/shift_reg_sipo.sv
`default_nettype none
// ============================================================================
//  Module   : shift_reg_sipo
//  Purpose  : Serial-in / parallel-out shift register with shift enable and
//             synchronous reset. New bits enter at the LSB, so the first bit
//             shifted in ends up in the MSB after WIDTH shifts.
//  Revision : 1.0  initial release
// ============================================================================
module shift_reg_sipo #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr_q;

    // A one-bit register has no lower slice to concatenate, so it is a plain
    // enabled flop; wider registers shift towards the MSB.
    if (WIDTH == 1) begin : g_single
        // Capture the line bit on each enabled cycle
        always_ff @(posedge clk) begin
            if (rst) begin
                sr_q <= '0;
            end else if (shift_en) begin
                sr_q <= serial_in;
            end
        end
    end else begin : g_multi
        // Shift left, inserting the line bit at the LSB
        always_ff @(posedge clk) begin
            if (rst) begin
                sr_q <= '0;
            end else if (shift_en) begin
                sr_q <= {sr_q[WIDTH-2:0], serial_in};
            end
        end
    end

    assign q = sr_q;

endmodule : shift_reg_sipo
`default_nettype wire

// File: rtl/serial_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_rx_ctrl
//  Purpose  : Frame sequencer for a SIPO shift register. Detects a start bit,
//             enables shifting for exactly WIDTH strobed data bits, checks the
//             stop bit and hands the word off through a one-entry valid/ready
//             output buffer that runs independently of the receiver.
//  Revision : 1.0  initial release
// ============================================================================
module serial_rx_ctrl
    import serial_rx_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    rx_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             frame_err_q;
    logic             overrun_q;

    logic             w_shift_en;
    logic [WIDTH-1:0] w_sr;

    // Data bits are only shifted on strobes while in the data phase
    assign w_shift_en = sample_en && (state_q == S_DATA);

    shift_reg_sipo #(
        .WIDTH (WIDTH)
    ) u_sr (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (w_shift_en),
        .serial_in (serial_in),
        .q         (w_sr)
    );

    // Frame FSM, bit counter, error pulses and output buffer with handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            // Consumer takes the word; a same-cycle load below overrides this
            if (valid_q && data_ready) begin
                valid_q <= 1'b0;
            end

            if (sample_en) begin
                case (state_q)
                    S_IDLE: begin
                        if (serial_in == START_BIT) begin
                            state_q <= S_DATA;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        cnt_q <= cnt_q + C_ONE;
                        if (cnt_q == C_LAST) begin
                            state_q <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        // A low stop bit is an error, never a new start bit
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        if (serial_in == STOP_BIT) begin
                            if (!valid_q || data_ready) begin
                                data_q  <= w_sr;
                                valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule : serial_rx_ctrl
`default_nettype wire
